// File: rtl/alu_sequencer.sv
// Operator sequencer for the 8-bit ALU: debounces the GO button into press events
// and steps LOAD_A -> LOAD_B -> EXEC -> SHOW, latching operands and the result.
module alu_sequencer #(
    parameter int DB_COUNT    = 500000,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_go,
    input  logic [7:0] data_in,
    input  logic [3:0] op_sel,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [3:0] op_out,
    output logic [7:0] y_out,
    output logic [1:0] state_out,
    output logic       err
);

    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam int TOW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;
    logic           press_q, press_d;

    state_t         state_q, state_d;
    logic [7:0]     a_q, a_d, b_q, b_d, y_q, y_d;
    logic [3:0]     op_q, op_d;
    logic           err_q, err_d;
    logic           start_q, start_d;
    logic [TOW-1:0] wait_q, wait_d;

    // Level change accepted only after the synced input disagrees for DB_COUNT+1 cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        press_d  = 1'b0;
        if (sync2_q == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DBW'(DB_COUNT)) begin
            db_cnt_d = '0;
            db_lvl_d = sync2_q;
            press_d  = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        err_d   = err_q;
        start_d = 1'b0;
        wait_d  = wait_q;
        case (state_q)
            LOAD_A: if (press_q) begin
                a_d     = data_in;
                err_d   = 1'b0;
                state_d = LOAD_B;
            end
            LOAD_B: if (press_q) begin
                b_d     = data_in;
                op_d    = op_sel;
                start_d = 1'b1;
                wait_d  = '0;
                state_d = EXEC;
            end
            EXEC: begin
                // done coincident with the launch strobe belongs to no operation
                if (alu_done && !start_q) begin
                    y_d     = alu_result;
                    state_d = SHOW;
                end else if (wait_q >= TOW'(ALU_TIMEOUT - 1)) begin
                    y_d     = 8'hFF;
                    err_d   = 1'b1;
                    state_d = SHOW;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SHOW: if (press_q) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
            press_q  <= 1'b0;
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            wait_q   <= '0;
        end else begin
            sync1_q  <= btn_go;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            press_q  <= press_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            y_q      <= y_d;
            err_q    <= err_d;
            start_q  <= start_d;
            wait_q   <= wait_d;
        end
    end

    assign alu_start = start_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign op_out    = op_q;
    assign y_out     = y_q;
    assign state_out = state_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues the expected snapshot for each
// state transition, a monitor compares on every observed transition.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_go;
    logic [7:0] data_in;
    logic [3:0] op_sel;
    logic       alu_start;
    logic       alu_done;
    logic [7:0] alu_result;
    logic [7:0] a_out, b_out, y_out;
    logic [3:0] op_out;
    logic [1:0] state_out;
    logic       err;

    alu_sequencer #(.DB_COUNT(4), .ALU_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .btn_go(btn_go), .data_in(data_in),
        .op_sel(op_sel), .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .a_out(a_out), .b_out(b_out), .op_out(op_out),
        .y_out(y_out), .state_out(state_out), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] st;
        logic [7:0] a, b, y;
        logic [3:0] op;
        logic       e;
        int         starts;
        int         cyc;    // -1: cycle not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   starts  = 0;
    logic prev_start = 1'b0;
    logic [1:0] prev_state = 2'd0;

    always @(posedge clock) cyc++;

    function automatic exp_t mk(input logic [1:0] st, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] op, input logic [7:0] y, input logic e,
                                input int s, input int c);
        exp_t x;
        x.st = st; x.a = a; x.b = b; x.op = op; x.y = y; x.e = e; x.starts = s; x.cyc = c;
        return x;
    endfunction

    // Monitor: one check per launch strobe (width) and per state transition (snapshot).
    always @(negedge clock) begin
        if (alu_start) begin
            n_tests++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL start_width: alu_start high two cycles in a row at cyc %0d", cyc);
            end
            starts++;
        end
        prev_start = alu_start;
        if (state_out != prev_state) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_transition: state %0d -> %0d at cyc %0d", prev_state, state_out, cyc);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (state_out !== x.st || a_out !== x.a || b_out !== x.b || op_out !== x.op ||
                    y_out !== x.y || err !== x.e || starts != x.starts || (x.cyc >= 0 && cyc != x.cyc)) begin
                    n_fail++;
                    $display("FAIL transition: got st=%0d a=%h b=%h op=%h y=%h err=%b starts=%0d cyc=%0d, want st=%0d a=%h b=%h op=%h y=%h err=%b starts=%0d cyc=%0d",
                             state_out, a_out, b_out, op_out, y_out, err, starts, cyc,
                             x.st, x.a, x.b, x.op, x.y, x.e, x.starts, x.cyc);
                end
            end
        end
        prev_state = state_out;
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Returns on the negedge where the new state is first visible.
    task automatic press(input logic [7:0] d, input logic [3:0] op);
        data_in = d;
        op_sel  = op;
        repeat (10) @(negedge clock);
        btn_go = 1'b1;
        repeat (8) @(negedge clock);
        btn_go = 1'b0;
    endtask

    initial begin
        int k, c0;
        reset = 1'b1; btn_go = 1'b0; data_in = '0; op_sel = '0; alu_done = 1'b0; alu_result = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {alu_start, a_out, b_out, op_out, y_out, state_out, err}, 0);
        reset = 1'b0;

        // 1: clean press latency, then short bounces
        data_in = 8'h3C;
        repeat (4) @(negedge clock);
        k = cyc;
        exp_q.push_back(mk(2'd1, 8'h3C, 8'h00, 4'h0, 8'h00, 1'b0, 0, k + 8));
        btn_go = 1'b1;
        repeat (10) @(negedge clock);
        btn_go = 1'b0;
        repeat (10) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            btn_go = 1'b1; repeat (3) @(negedge clock);
            btn_go = 1'b0; repeat (3) @(negedge clock);
        end
        repeat (12) @(negedge clock);
        check("bounce_no_press", state_out, 1);

        // 2/3: B load, launch, done ignored on strobe cycle, real done after 3 cycles
        exp_q.push_back(mk(2'd2, 8'h3C, 8'h05, 4'h2, 8'h00, 1'b0, 1, -1));
        press(8'h05, 4'h2);
        alu_done = 1'b1; alu_result = 8'h99;
        @(negedge clock); alu_done = 1'b0;
        @(negedge clock);
        exp_q.push_back(mk(2'd3, 8'h3C, 8'h05, 4'h2, 8'h41, 1'b0, 1, -1));
        @(negedge clock); alu_done = 1'b1; alu_result = 8'h41;
        @(negedge clock); alu_done = 1'b0;
        repeat (2) @(negedge clock);
        alu_done = 1'b1; alu_result = 8'h77;
        @(negedge clock); alu_done = 1'b0;
        check("done_outside_exec", y_out, 8'h41);
        exp_q.push_back(mk(2'd0, 8'h3C, 8'h05, 4'h2, 8'h41, 1'b0, 1, -1));
        press(8'hEE, 4'hE);

        // 4: timeout, err held through LOAD_A, cleared by next A load
        exp_q.push_back(mk(2'd1, 8'h11, 8'h05, 4'h2, 8'h41, 1'b0, 1, -1));
        press(8'h11, 4'h0);
        exp_q.push_back(mk(2'd2, 8'h11, 8'h22, 4'h7, 8'h41, 1'b0, 2, -1));
        press(8'h22, 4'h7);
        c0 = cyc;
        exp_q.push_back(mk(2'd3, 8'h11, 8'h22, 4'h7, 8'hFF, 1'b1, 2, c0 + 15));
        repeat (20) @(negedge clock);
        exp_q.push_back(mk(2'd0, 8'h11, 8'h22, 4'h7, 8'hFF, 1'b1, 2, -1));
        press(8'h00, 4'h0);
        exp_q.push_back(mk(2'd1, 8'h44, 8'h22, 4'h7, 8'hFF, 1'b0, 2, -1));
        press(8'h44, 4'h0);

        // done on the last cycle before timeout wins
        exp_q.push_back(mk(2'd2, 8'h44, 8'h33, 4'h1, 8'hFF, 1'b0, 3, -1));
        press(8'h33, 4'h1);
        c0 = cyc;
        exp_q.push_back(mk(2'd3, 8'h44, 8'h33, 4'h1, 8'h5A, 1'b0, 3, c0 + 15));
        repeat (14) @(negedge clock);
        alu_done = 1'b1; alu_result = 8'h5A;
        @(negedge clock); alu_done = 1'b0;
        exp_q.push_back(mk(2'd0, 8'h44, 8'h33, 4'h1, 8'h5A, 1'b0, 3, -1));
        press(8'h00, 4'h0);
        exp_q.push_back(mk(2'd1, 8'h01, 8'h33, 4'h1, 8'h5A, 1'b0, 3, -1));
        press(8'h01, 4'h0);

        // 5: press during EXEC is discarded
        exp_q.push_back(mk(2'd2, 8'h01, 8'h02, 4'h3, 8'h5A, 1'b0, 4, -1));
        press(8'h02, 4'h3);
        c0 = cyc;
        btn_go = 1'b1;
        repeat (9) @(negedge clock);
        btn_go = 1'b0;
        exp_q.push_back(mk(2'd3, 8'h01, 8'h02, 4'h3, 8'h6B, 1'b0, 4, c0 + 10));
        alu_done = 1'b1; alu_result = 8'h6B;
        @(negedge clock); alu_done = 1'b0;
        repeat (15) @(negedge clock);
        check("exec_press_dropped", state_out, 3);

        // 6: reset mid-EXEC
        exp_q.push_back(mk(2'd0, 8'h01, 8'h02, 4'h3, 8'h6B, 1'b0, 4, -1));
        press(8'h00, 4'h0);
        exp_q.push_back(mk(2'd1, 8'hAA, 8'h02, 4'h3, 8'h6B, 1'b0, 4, -1));
        press(8'hAA, 4'h0);
        exp_q.push_back(mk(2'd2, 8'hAA, 8'hBB, 4'h4, 8'h6B, 1'b0, 5, -1));
        press(8'hBB, 4'h4);
        repeat (2) @(negedge clock);
        exp_q.push_back(mk(2'd0, 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 5, -1));
        #2 reset = 1'b1;
        #1 check("reset_mid_exec", {alu_start, a_out, b_out, op_out, y_out, state_out, err}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("no_start_after_reset", starts, 5);
        check("state_after_reset", state_out, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
